change_dispenser: RTL



---
 rtl/vm_pkg.sv | 28 ++
 rtl/change_dispenser_if.sv | 12 +
 rtl/change_dispenser_coin_selector.sv | 36 +++
 rtl/change_dispenser.sv | 135 +++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared vending-machine types: coin encodings and values, dispenser states, error codes.
package vm_pkg;

  typedef enum logic [1:0] {
    COIN_500  = 2'b00,
    COIN_1000 = 2'b01,
    COIN_2000 = 2'b10,
    COIN_5000 = 2'b11
  } coin_t;

  localparam int DEF_VAL_500  = 5;
  localparam int DEF_VAL_1000 = 10;
  localparam int DEF_VAL_2000 = 20;
  localparam int DEF_VAL_5000 = 50;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAN,
    ST_DISPENSE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNDERPAY = 2'b01;
  localparam logic [1:0] ERR_NOCHANGE = 2'b10;

endpackage

// File: rtl/change_dispenser_if.sv
// Coin output handshake between the change dispenser and the payout mechanism.
interface change_dispenser_if;
  import vm_pkg::*;

  logic  coin_valid;
  coin_t coin_type;
  logic  coin_ready;

  modport master (output coin_valid, output coin_type, input coin_ready);
  modport slave  (input coin_valid, input coin_type, output coin_ready);

endinterface

// File: rtl/change_dispenser_coin_selector.sv
// Combinational pick of the largest denomination that fits the amount and is in stock.
module coin_selector
  import vm_pkg::*;
#(
  parameter int AMT_W    = 16,
  parameter int CNT_W    = 4,
  parameter int VAL_500  = DEF_VAL_500,
  parameter int VAL_1000 = DEF_VAL_1000,
  parameter int VAL_2000 = DEF_VAL_2000,
  parameter int VAL_5000 = DEF_VAL_5000
) (
  input  logic [AMT_W-1:0]          amount,
  input  logic [3:0][CNT_W-1:0]     counts,
  output logic                      found,
  output coin_t                     coin_type
);

  always_comb begin
    found     = 1'b0;
    coin_type = COIN_500;
    if (counts[COIN_5000] != '0 && amount >= AMT_W'(VAL_5000)) begin
      found     = 1'b1;
      coin_type = COIN_5000;
    end else if (counts[COIN_2000] != '0 && amount >= AMT_W'(VAL_2000)) begin
      found     = 1'b1;
      coin_type = COIN_2000;
    end else if (counts[COIN_1000] != '0 && amount >= AMT_W'(VAL_1000)) begin
      found     = 1'b1;
      coin_type = COIN_1000;
    end else if (counts[COIN_500] != '0 && amount >= AMT_W'(VAL_500)) begin
      found     = 1'b1;
      coin_type = COIN_500;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Plans a greedy exact-change payout from the cash box, then emits it one coin per handshake.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W    = 16,
  parameter int CNT_W    = 4,
  parameter int VAL_500  = DEF_VAL_500,
  parameter int VAL_1000 = DEF_VAL_1000,
  parameter int VAL_2000 = DEF_VAL_2000,
  parameter int VAL_5000 = DEF_VAL_5000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [AMT_W-1:0]     paid,
  input  logic [AMT_W-1:0]     cost,
  input  logic [CNT_W-1:0]     avail_500,
  input  logic [CNT_W-1:0]     avail_1000,
  input  logic [CNT_W-1:0]     avail_2000,
  input  logic [CNT_W-1:0]     avail_5000,
  change_dispenser_if.master   coin,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [AMT_W-1:0]     change_amt,
  output logic [CNT_W-1:0]     used_500,
  output logic [CNT_W-1:0]     used_1000,
  output logic [CNT_W-1:0]     used_2000,
  output logic [CNT_W-1:0]     used_5000
);

  state_t                  state, state_nx;
  logic [AMT_W-1:0]        rem;
  logic [3:0][CNT_W-1:0]   avail, shadow, used, pend;
  logic                    plan_found, disp_found;
  coin_t                   plan_coin, disp_coin;

  assign avail = {avail_5000, avail_2000, avail_1000, avail_500};

  function automatic logic [AMT_W-1:0] coin_val(input coin_t c);
    case (c)
      COIN_5000: return AMT_W'(VAL_5000);
      COIN_2000: return AMT_W'(VAL_2000);
      COIN_1000: return AMT_W'(VAL_1000);
      default:   return AMT_W'(VAL_500);
    endcase
  endfunction

  coin_selector #(
    .AMT_W(AMT_W), .CNT_W(CNT_W),
    .VAL_500(VAL_500), .VAL_1000(VAL_1000), .VAL_2000(VAL_2000), .VAL_5000(VAL_5000)
  ) u_plan_sel (
    .amount(rem), .counts(shadow), .found(plan_found), .coin_type(plan_coin)
  );

  // All-ones amount turns the selector into "largest denomination still pending".
  coin_selector #(
    .AMT_W(AMT_W), .CNT_W(CNT_W),
    .VAL_500(VAL_500), .VAL_1000(VAL_1000), .VAL_2000(VAL_2000), .VAL_5000(VAL_5000)
  ) u_disp_sel (
    .amount('1), .counts(pend), .found(disp_found), .coin_type(disp_coin)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (start) state_nx = (cost > paid) ? ST_ERR : ST_PLAN;
      ST_PLAN:     if (rem == '0) state_nx = ST_DISPENSE;
                   else if (!plan_found) state_nx = ST_ERR;
      ST_DISPENSE: if (!disp_found) state_nx = ST_DONE;
      ST_DONE:     state_nx = ST_IDLE;
      ST_ERR:      state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // used is the reported plan; pend is the copy consumed by the handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem        <= '0;
      change_amt <= '0;
      err_code   <= ERR_NONE;
      shadow     <= '0;
      used       <= '0;
      pend       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          shadow   <= avail;
          used     <= '0;
          pend     <= '0;
          err_code <= ERR_NONE;
          if (cost > paid) begin
            err_code <= ERR_UNDERPAY;
          end else begin
            change_amt <= paid - cost;
            rem        <= paid - cost;
          end
        end
        ST_PLAN: if (rem != '0) begin
          if (plan_found) begin
            rem               <= rem - coin_val(plan_coin);
            shadow[plan_coin] <= shadow[plan_coin] - 1'b1;
            used[plan_coin]   <= used[plan_coin] + 1'b1;
            pend[plan_coin]   <= pend[plan_coin] + 1'b1;
          end else begin
            err_code <= ERR_NOCHANGE;
          end
        end
        ST_DISPENSE: if (disp_found && coin.coin_ready) begin
          pend[disp_coin] <= pend[disp_coin] - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_DONE);
  assign error           = (state == ST_ERR);
  assign coin.coin_valid = (state == ST_DISPENSE) && disp_found;
  assign coin.coin_type  = disp_coin;

  assign used_500  = used[COIN_500];
  assign used_1000 = used[COIN_1000];
  assign used_2000 = used[COIN_2000];
  assign used_5000 = used[COIN_5000];

endmodule
